irq_exception_ctrl: RTL and testbench
=====================================

Name: irq_exception_ctrl

Overview:
Sequential interrupt/exception controller paired with the combinational instruction decoder in the pipelined CPU. It latches N edge-triggered interrupt sources with per-channel mask and fixed priority, and tracks kernel/user mode in place of the PC[31] input. It accepts undefined-instruction exceptions from the decoder at the ID stage, captures EPC and cause, and issues a one-cycle registered redirect and flush. It handles return from kernel mode through an eret strobe.

Parameters:
NUM_IRQ, 4, number of interrupt channels (1..16)
PC_W, 32, PC width
IRQ_VECTOR, 32'h80000004, interrupt entry PC
EXC_VECTOR, 32'h80000008, exception entry PC

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
irq_in  in  NUM_IRQ  raw interrupt lines, synchronous to clk, level
mask_wr  in  1  write strobe for the mask register
mask_wdata  in  NUM_IRQ  new mask value; 1 = enabled
irq_mask  out  NUM_IRQ  current mask
exc_undef  in  1  decoder flags the ID instruction as undefined
eret  in  1  ID instruction is an exception return
id_valid  in  1  ID stage holds a real instruction
id_pc  in  PC_W  PC of the ID instruction
pipe_stall  in  1  ID stage is stalled this cycle
kern_mode  out  1  1 = kernel mode; feeds the decoder's PC31 input
redirect  out  1  one-cycle pulse: fetch from redirect_pc, flush IF/ID
redirect_pc  out  PC_W  target PC while redirect = 1
epc  out  PC_W  saved return PC
cause  out  5  bit4 = exception, bits3:0 = IRQ channel index
irq_ack  out  NUM_IRQ  one-hot one-cycle pulse for the serviced channel

Behaviour:
- Reset (async, reset = 0): state = USER; pending = 0; irq_mask = 0; kern_mode = 0; redirect = 0; redirect_pc = 0; epc = 0; cause = 0; irq_ack = 0; previous-level registers = 0.
- Edge detect: channel i sets pending[i] on an irq_in[i] 0->1 transition (previous level registered).
  - Pending stays set until acked, regardless of the mask.
  - A masked pending channel is held, not dropped, and is taken once unmasked.
- Set and ack on the same channel in the same cycle: set wins, so pending stays 1.
- mask_wr updates irq_mask at the clock edge. A take decision in the same cycle uses the old mask.
- The take condition, evaluated combinationally in cycle T, requires state = USER, id_valid = 1 and pipe_stall = 0.
- Exception has priority over IRQ:
  - exc_undef = 1: take exception. At T+1: redirect = 1, redirect_pc = EXC_VECTOR, epc = id_pc + 4, cause = 5'b10000.
  - Otherwise, any (pending & irq_mask) != 0: take the lowest-index enabled channel k. At T+1: redirect = 1, redirect_pc = IRQ_VECTOR, epc = id_pc (instruction re-executes), cause = {1'b0, k}, irq_ack[k] = 1, pending[k] cleared.
- States:
  - USER: taking -> ENTER.
  - ENTER: lasts one cycle, the flush cycle. All inputs except edge detection and mask_wr are ignored. Then -> KERNEL.
  - KERNEL: kern_mode = 1. No IRQ or exception is taken; undefined instructions are treated as nop by the decoder. On eret = 1 with id_valid = 1 and pipe_stall = 0: at T+1 redirect = 1, redirect_pc = epc, state -> USER.
- kern_mode = 1 in ENTER and KERNEL, 0 in USER; it is a registered output.
- eret in USER is ignored.
- Latency: decision in T; redirect and irq_ack visible in T+1 for exactly one cycle.
- epc and cause hold their values until the next take.
- Stall: a pending IRQ waits while pipe_stall = 1 or id_valid = 0; nothing is lost.
- Reset mid-ENTER or mid-KERNEL returns to USER with all pending cleared.
- PC arithmetic wraps modulo 2^PC_W.

Test Plan:
- Reset release, irq_mask = 0, pulse irq_in[2] -> no redirect. Then write mask = 4'b0100 with id_valid = 1, id_pc = 0x00000040 -> next cycle redirect = 1, redirect_pc = 0x80000004, epc = 0x40, cause = 5'h02, irq_ack = 4'b0100, kern_mode = 1.
- Simultaneous edges on irq_in[3] and irq_in[1], mask = 4'hF -> channel 1 is taken first. After eret with epc = 0x40, channel 3 is taken next -> cause = 5'h03.
- exc_undef = 1 together with pending IRQ0, id_pc = 0x100 -> redirect_pc = 0x80000008, epc = 0x104, cause = 5'h10, irq_ack = 0, and IRQ0 remains pending.
- In KERNEL, pulse irq_in[0] and assert exc_undef -> no redirect. Then eret -> redirect_pc = epc, kern_mode = 0. IRQ0 is taken on the following valid cycle.
- pipe_stall = 1 for 5 cycles with IRQ1 enabled -> no redirect until stall drops, then redirect in the next cycle. Also: same-cycle edge and ack on channel 1 -> pending[1] stays 1.
- Assert reset in ENTER state -> all outputs return to reset values immediately (async), and no redirect after release.

Source files
------------

// File: rtl/irq_exception_ctrl.sv
// Interrupt/exception controller: edge-latched masked IRQs with fixed priority, undefined-instruction traps, eret.
// Take decision in cycle T; redirect/irq_ack/epc/cause registered and visible in T+1. Stalls delay the take, never drop it.
module irq_exception_ctrl #(
  parameter int              NUM_IRQ    = 4,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] IRQ_VECTOR = 32'h80000004,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'h80000008
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] irq_mask,
  input  logic               exc_undef,
  input  logic               eret,
  input  logic               id_valid,
  input  logic [PC_W-1:0]    id_pc,
  input  logic               pipe_stall,
  output logic               kern_mode,
  output logic               redirect,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    epc,
  output logic [4:0]         cause,
  output logic [NUM_IRQ-1:0] irq_ack
);

  typedef enum logic [1:0] {USER, ENTER, KERNEL} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               kern_q, kern_d;
  logic               redirect_q, redirect_d;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic [4:0]         cause_q, cause_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] enabled;
  logic [3:0]         chan;
  logic               take_ok, take_exc, take_irq, eret_ok;

  assign rise    = irq_in & ~irq_prev_q;
  assign enabled = pending_q & mask_q;
  assign take_ok  = (state_q == USER) && id_valid && !pipe_stall;
  assign take_exc = take_ok && exc_undef;
  assign take_irq = take_ok && !exc_undef && (|enabled);
  assign eret_ok  = (state_q == KERNEL) && eret && id_valid && !pipe_stall;

  // Descending scan so the lowest enabled index is the one left in chan.
  always_comb begin
    chan = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (enabled[i]) chan = 4'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_wr ? mask_wdata : mask_q;
    ack_d         = '0;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    epc_d         = epc_q;
    cause_d       = cause_q;

    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_d[i] = take_irq && (chan == 4'(i));
    end

    case (state_q)
      USER: begin
        if (take_exc) begin
          state_d       = ENTER;
          redirect_d    = 1'b1;
          redirect_pc_d = EXC_VECTOR;
          epc_d         = id_pc + PC_W'(4);
          cause_d       = 5'b10000;
        end else if (take_irq) begin
          state_d       = ENTER;
          redirect_d    = 1'b1;
          redirect_pc_d = IRQ_VECTOR;
          epc_d         = id_pc;
          cause_d       = {1'b0, chan};
        end
      end
      ENTER: state_d = KERNEL;
      KERNEL: begin
        if (eret_ok) begin
          state_d       = USER;
          redirect_d    = 1'b1;
          redirect_pc_d = epc_q;
        end
      end
      default: state_d = USER;
    endcase

    // A new edge on the channel being acked re-arms it.
    pending_d = (pending_q & ~ack_d) | rise;
    kern_d    = (state_d != USER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= USER;
      irq_prev_q    <= '0;
      pending_q     <= '0;
      mask_q        <= '0;
      kern_q        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      epc_q         <= '0;
      cause_q       <= '0;
      ack_q         <= '0;
    end else begin
      state_q       <= state_d;
      irq_prev_q    <= irq_in;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      kern_q        <= kern_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      ack_q         <= ack_d;
    end
  end

  assign irq_mask    = mask_q;
  assign kern_mode   = kern_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign irq_ack     = ack_q;

endmodule

// File: tb/tb_irq_exception_ctrl.sv
// Scoreboard bench for irq_exception_ctrl: every expected redirect is queued when its decision cycle is driven.
module tb_irq_exception_ctrl;
  localparam logic [31:0] IRQ_V = 32'h80000004;
  localparam logic [31:0] EXC_V = 32'h80000008;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic [3:0]  ack;
    logic        kern;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        mask_wr = 1'b0;
  logic [3:0]  mask_wdata = '0;
  logic [3:0]  irq_mask;
  logic        exc_undef = 1'b0;
  logic        eret = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic        pipe_stall = 1'b0;
  logic        kern_mode;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic [3:0]  irq_ack;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] epc_m = '0;
  logic [4:0]  cause_m = '0;

  irq_exception_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_wr(mask_wr), .mask_wdata(mask_wdata),
    .irq_mask(irq_mask), .exc_undef(exc_undef), .eret(eret), .id_valid(id_valid), .id_pc(id_pc),
    .pipe_stall(pipe_stall), .kern_mode(kern_mode), .redirect(redirect), .redirect_pc(redirect_pc),
    .epc(epc), .cause(cause), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // Output monitor: every redirect must match the oldest queued expectation.
  always @(negedge clk) begin
    if (redirect === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_redirect got pc=%h epc=%h cause=%h ack=%b", redirect_pc, epc, cause, irq_ack);
      end else begin
        e = sb.pop_front();
        if ({redirect_pc, epc, cause, irq_ack, kern_mode} !== {e.pc, e.epc, e.cause, e.ack, e.kern}) begin
          failures++;
          $display("FAIL redirect_event got pc=%h epc=%h cause=%h ack=%b kern=%b want pc=%h epc=%h cause=%h ack=%b kern=%b",
                   redirect_pc, epc, cause, irq_ack, kern_mode, e.pc, e.epc, e.cause, e.ack, e.kern);
        end
      end
    end else if (reset === 1'b1) begin
      checks++;
      if (irq_ack !== 4'b0) begin
        failures++;
        $display("FAIL ack_without_redirect got ack=%b want 0000", irq_ack);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_irq(input logic [3:0] lines);
    irq_in = lines;
    cyc();
    irq_in = '0;
    cyc();
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_wr = 1'b1;
    mask_wdata = m;
    cyc();
    mask_wr = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] ep, input logic [4:0] c,
                          input logic [3:0] a, input logic k);
    exp_t x;
    x.pc = pc; x.epc = ep; x.cause = c; x.ack = a; x.kern = k;
    sb.push_back(x);
  endtask

  // Drives one take decision in USER and walks through ENTER into KERNEL.
  task automatic enter_kernel(input logic [31:0] pc, input logic exc, input int k);
    id_valid = 1'b1;
    id_pc = pc;
    exc_undef = exc;
    if (exc) begin
      epc_m = pc + 32'd4;
      cause_m = 5'h10;
      push_exp(EXC_V, epc_m, cause_m, 4'b0, 1'b1);
    end else begin
      epc_m = pc;
      cause_m = 5'(k);
      push_exp(IRQ_V, epc_m, cause_m, 4'b1 << k, 1'b1);
    end
    cyc();
    id_valid = 1'b0;
    exc_undef = 1'b0;
    cyc();
  endtask

  task automatic do_eret();
    push_exp(epc_m, epc_m, cause_m, 4'b0, 1'b0);
    eret = 1'b1;
    id_valid = 1'b1;
    cyc();
    eret = 1'b0;
    id_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({redirect, kern_mode, irq_mask, irq_ack} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctrl got redirect=%b kern=%b mask=%b ack=%b want all 0", redirect, kern_mode, irq_mask, irq_ack);
    end
    checks++;
    if ({redirect_pc, epc, cause} !== 69'b0) begin
      failures++;
      $display("FAIL reset_regs got rpc=%h epc=%h cause=%h want 0", redirect_pc, epc, cause);
    end
    cyc(2);
    reset = 1'b1;
    cyc(2);
  endtask

  task automatic test_mask_enable();
    id_valid = 1'b1;
    id_pc = 32'h40;
    pulse_irq(4'b0100);
    cyc(2);
    checks++;
    if (redirect !== 1'b0) begin
      failures++;
      $display("FAIL masked_no_take got redirect=%b want 0", redirect);
    end
    mask_wr = 1'b1;
    mask_wdata = 4'b0100;
    cyc();
    mask_wr = 1'b0;
    checks++;
    if (redirect !== 1'b0) begin
      failures++;
      $display("FAIL old_mask_used got redirect=%b want 0", redirect);
    end
    enter_kernel(32'h40, 1'b0, 2);
    checks++;
    if ({kern_mode, irq_mask} !== 5'b1_0100) begin
      failures++;
      $display("FAIL kernel_after_irq got kern=%b mask=%b want 1 0100", kern_mode, irq_mask);
    end
    do_eret();
    checks++;
    if (kern_mode !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL mask_enable_drain got kern=%b queued=%0d want 0 0", kern_mode, sb.size());
    end
  endtask

  task automatic test_priority();
    write_mask(4'hF);
    pulse_irq(4'b1010);
    enter_kernel(32'h40, 1'b0, 1);
    do_eret();
    enter_kernel(32'h60, 1'b0, 3);
    do_eret();
    checks++;
    if (sb.size() != 0 || cause !== 5'h03) begin
      failures++;
      $display("FAIL priority_drain got queued=%0d cause=%h want 0 03", sb.size(), cause);
    end
  endtask

  task automatic test_exception();
    pulse_irq(4'b0001);
    enter_kernel(32'h100, 1'b1, 0);
    do_eret();
    enter_kernel(32'h200, 1'b0, 0);
    do_eret();
    checks++;
    if (sb.size() != 0 || epc !== 32'h200) begin
      failures++;
      $display("FAIL exception_drain got queued=%0d epc=%h want 0 00000200", sb.size(), epc);
    end
  endtask

  task automatic test_kernel_ignore();
    enter_kernel(32'h300, 1'b1, 0);
    irq_in = 4'b0001;
    exc_undef = 1'b1;
    id_valid = 1'b1;
    id_pc = 32'h310;
    cyc();
    irq_in = '0;
    cyc(2);
    checks++;
    if (redirect !== 1'b0 || kern_mode !== 1'b1) begin
      failures++;
      $display("FAIL kernel_ignores got redirect=%b kern=%b want 0 1", redirect, kern_mode);
    end
    exc_undef = 1'b0;
    id_valid = 1'b0;
    do_eret();
    enter_kernel(32'h308, 1'b0, 0);
    do_eret();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL kernel_ignore_drain got queued=%0d want 0", sb.size());
    end
  endtask

  task automatic test_stall();
    pulse_irq(4'b0010);
    id_valid = 1'b1;
    id_pc = 32'h400;
    pipe_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (redirect !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got redirect=%b want 0", i, redirect);
      end
    end
    pipe_stall = 1'b0;
    irq_in = 4'b0010;
    enter_kernel(32'h400, 1'b0, 1);
    irq_in = '0;
    do_eret();
    enter_kernel(32'h404, 1'b0, 1);
    do_eret();
    id_valid = 1'b1;
    cyc(3);
    id_valid = 1'b0;
    checks++;
    if (redirect !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL stall_drain got redirect=%b queued=%0d want 0 0", redirect, sb.size());
    end
  endtask

  task automatic test_reset_in_enter();
    pulse_irq(4'b1100);
    id_valid = 1'b1;
    id_pc = 32'h500;
    epc_m = 32'h500;
    cause_m = 5'h02;
    push_exp(IRQ_V, epc_m, cause_m, 4'b0100, 1'b1);
    cyc();
    id_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({redirect, kern_mode, irq_mask, irq_ack} !== 10'b0) begin
      failures++;
      $display("FAIL async_reset_ctrl got redirect=%b kern=%b mask=%b ack=%b want all 0", redirect, kern_mode, irq_mask, irq_ack);
    end
    checks++;
    if ({redirect_pc, epc, cause} !== 69'b0) begin
      failures++;
      $display("FAIL async_reset_regs got rpc=%h epc=%h cause=%h want 0", redirect_pc, epc, cause);
    end
    #3;
    reset = 1'b1;
    cyc();
    write_mask(4'hF);
    id_valid = 1'b1;
    cyc(4);
    id_valid = 1'b0;
    checks++;
    if (redirect !== 1'b0 || kern_mode !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL pending_cleared got redirect=%b kern=%b queued=%0d want 0 0 0", redirect, kern_mode, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_mask_enable();
    test_priority();
    test_exception();
    test_kernel_ignore();
    test_stall();
    test_reset_in_enter();
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
